// File: rtl/lfsr_stepper_pkg.sv
// Shared definitions for the LFSR stepper: controller state encodings.
package lfsr_stepper_pkg;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/lfsr_stepper_prescaler.sv
// Free-running prescaler with enable and synchronous clear; wrap flags the all-ones cycle.
module lfsr_stepper_prescaler #(
  parameter int DIV_BITS = 23
) (
  input  logic clki,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap,
  output logic msb
);

  logic [DIV_BITS-1:0] cnt;

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DIV_BITS'(1);
    end
  end

  assign wrap = en && (cnt == '1);
  assign msb  = cnt[DIV_BITS-1];

endmodule

// File: rtl/lfsr_stepper.sv
// LFSR generator with run/halt/single-step control, seed load, lock-up recovery and period measurement.
module lfsr_stepper
  import lfsr_stepper_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DIV_BITS = 23,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter bit               GALOIS   = 1'b0
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] out,
  output logic             adv,
  output logic             blink,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_vld
);

  // In Galois form taps[0] is the constant term fed back into bit 0.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] tp,
                                                 input bit               galois);
    if (galois)
      return {cur[WIDTH-2:0], 1'b0} ^ ({WIDTH{cur[WIDTH-1]}} & tp);
    else
      return {cur[WIDTH-2:0], ^(cur & tp)};
  endfunction

  state_t           state;
  logic             step_q;
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] count;

  logic             wrap;
  logic             entering_run;
  logic             adv_req;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] out_new;
  logic [WIDTH-1:0] count_inc;

  assign entering_run = (state == ST_HALT) && run;
  assign adv_req      = (state == ST_RUN) ? wrap : (step && !step_q);
  assign seed_eff     = (seed == '0) ? SEED : seed;
  assign out_new      = (out == '0) ? SEED : lfsr_next(out, taps, GALOIS);
  assign count_inc    = (count == '1) ? count : count + WIDTH'(1);

  lfsr_stepper_prescaler #(
    .DIV_BITS (DIV_BITS)
  ) u_prescaler (
    .clki  (clki),
    .rst_n (rst_n),
    .en    (state == ST_RUN),
    .clr   (load || entering_run),
    .wrap  (wrap),
    .msb   (blink)
  );

  // Load wins over a coincident advance, which is simply dropped.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HALT;
      step_q     <= 1'b0;
      out        <= SEED;
      ref_val    <= SEED;
      count      <= '0;
      adv        <= 1'b0;
      lockup     <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      step_q <= step;
      adv    <= 1'b0;

      case (state)
        ST_HALT: if (run)  state <= ST_RUN;
        ST_RUN:  if (!run) state <= ST_HALT;
        default:           state <= ST_HALT;
      endcase

      if (load) begin
        out        <= seed_eff;
        ref_val    <= seed_eff;
        count      <= '0;
        lockup     <= 1'b0;
        period_vld <= 1'b0;
      end else if (adv_req) begin
        out   <= out_new;
        adv   <= 1'b1;
        count <= count_inc;
        if (out == '0)
          lockup <= 1'b1;
        if ((out_new == ref_val) && !period_vld) begin
          period     <= count_inc;
          period_vld <= 1'b1;
        end
      end
    end
  end

endmodule
